// File: rtl/hack_memory_map_if.sv
// CPU-side data-memory bus for the Hack memory map: one word address,
// write data and write strobe going in, read data coming back.
interface hack_memory_map_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  // No valid/ready pair: the bus never stalls. load is a one-cycle write
  // strobe taken on the rising edge it is high; out carries the word at
  // address as sampled on the previous rising edge (fixed 1-cycle latency).
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic              load;
  logic [DATA_W-1:0] out;

  modport master (output address, in, load, input out);
  modport slave  (input address, in, load, output out);
endinterface

// File: rtl/hack_memory_map.sv
// Hack data-memory map: RAM, dual-ported screen buffer and keyboard register
// behind one CPU port, with a power-up wait/clear sequencer and illegal-write flag.
module hack_memory_map #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 15,
  parameter int RAM_DEPTH     = 16384,
  parameter int SCREEN_BASE   = 16384,
  parameter int SCREEN_DEPTH  = 8192,
  parameter int KBD_ADDR      = 24576,
  parameter int INIT_WAIT     = 25000000,
  parameter int CLEAR_ON_INIT = 1,
  localparam int SA_W = (SCREEN_DEPTH > 1) ? $clog2(SCREEN_DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  hack_memory_map_if.slave          bus,
  input  logic [7:0]                keyboard,
  input  logic [SA_W-1:0]           screen_read_address,
  output logic [DATA_W-1:0]         screen_q,
  output logic                      ready,
  output logic                      bad_access,
  output logic [1:0]                state_dbg
);

  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CLR_DEPTH = (RAM_DEPTH > SCREEN_DEPTH) ? RAM_DEPTH : SCREEN_DEPTH;
  localparam int CLR_W     = (CLR_DEPTH > 1) ? $clog2(CLR_DEPTH) : 1;
  localparam int WAIT_W    = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;

  typedef enum logic [1:0] {S_WAIT = 2'd0, S_CLEAR = 2'd1, S_RUN = 2'd2} state_t;
  typedef enum logic [1:0] {R_RAM, R_SCR, R_KBD, R_UNM} region_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [CLR_W-1:0]    clr_idx_q;
  logic                wait_done, clr_done, clearing;

  region_t             region, rd_region_q;
  logic [RAM_AW-1:0]   ram_idx, ram_wa;
  logic [SA_W-1:0]     scr_idx, scr_wa;
  logic                cpu_wr, ram_we, scr_we;
  logic [DATA_W-1:0]   ram_wd, scr_wd;

  logic [DATA_W-1:0]   ram [RAM_DEPTH];
  logic [DATA_W-1:0]   scr [SCREEN_DEPTH];
  logic [DATA_W-1:0]   ram_rd, scr_rd, scan_rd;
  logic                scan_vld_q;
  logic [7:0]          kbd_s1_q, kbd_s2_q, kbd_rd_q;
  logic                bad_access_q;

  // Sequencer: state register, next state, outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_WAIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (wait_done) state_d = (CLEAR_ON_INIT != 0) ? S_CLEAR : S_RUN;
      S_CLEAR: if (clr_done) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_RUN);
    clearing  = (state_q == S_CLEAR);
    state_dbg = state_q;
  end

  assign wait_done = (wait_cnt_q == WAIT_W'(INIT_WAIT - 1));
  assign clr_done  = (clr_idx_q == CLR_W'(CLR_DEPTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      clr_idx_q  <= '0;
    end else begin
      if (state_q == S_WAIT) wait_cnt_q <= wait_done ? '0 : wait_cnt_q + WAIT_W'(1);
      if (clearing)          clr_idx_q  <= clr_done ? '0 : clr_idx_q + CLR_W'(1);
    end
  end

  // Address decode; the screen index is the offset from its base, truncated.
  always_comb begin
    if (32'(bus.address) < 32'(RAM_DEPTH))
      region = R_RAM;
    else if (32'(bus.address) >= 32'(SCREEN_BASE) &&
             32'(bus.address) < 32'(SCREEN_BASE + SCREEN_DEPTH))
      region = R_SCR;
    else if (32'(bus.address) == 32'(KBD_ADDR))
      region = R_KBD;
    else
      region = R_UNM;
  end

  assign ram_idx = RAM_AW'(bus.address);
  assign scr_idx = SA_W'(bus.address - ADDR_W'(SCREEN_BASE));
  assign cpu_wr  = (state_q == S_RUN) && bus.load;

  // During CLEAR the sequencer owns the write ports; CPU loads are dropped.
  always_comb begin
    ram_we = clearing ? (32'(clr_idx_q) < 32'(RAM_DEPTH))    : (cpu_wr && region == R_RAM);
    scr_we = clearing ? (32'(clr_idx_q) < 32'(SCREEN_DEPTH)) : (cpu_wr && region == R_SCR);
    ram_wa = clearing ? RAM_AW'(clr_idx_q) : ram_idx;
    scr_wa = clearing ? SA_W'(clr_idx_q)   : scr_idx;
    ram_wd = clearing ? '0 : bus.in;
    scr_wd = clearing ? '0 : bus.in;
  end

  // Read-before-write: a same-cycle read of the written word returns old data.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    ram_rd <= ram[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (scr_we) scr[scr_wa] <= scr_wd;
    scr_rd  <= scr[scr_idx];
    scan_rd <= scr[screen_read_address];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_region_q  <= R_UNM;
      scan_vld_q   <= 1'b0;
      kbd_s1_q     <= '0;
      kbd_s2_q     <= '0;
      kbd_rd_q     <= '0;
      bad_access_q <= 1'b0;
    end else begin
      rd_region_q <= region;
      scan_vld_q  <= 1'b1;
      kbd_s1_q    <= keyboard;
      kbd_s2_q    <= kbd_s1_q;
      kbd_rd_q    <= kbd_s2_q;
      if (cpu_wr && (region == R_KBD || region == R_UNM)) bad_access_q <= 1'b1;
    end
  end

  always_comb begin
    case (rd_region_q)
      R_RAM:   bus.out = ram_rd;
      R_SCR:   bus.out = scr_rd;
      R_KBD:   bus.out = DATA_W'(kbd_rd_q);
      default: bus.out = '0;
    endcase
  end

  assign screen_q   = scan_vld_q ? scan_rd : '0;
  assign bad_access = bad_access_q;

endmodule

// File: doc/hack_memory_map.md
# hack_memory_map

Parametrised Hack data-memory map: general-purpose RAM, dual-ported screen buffer and keyboard register behind one CPU address/data port. Sits between the Hack CPU and the VGA scan-out. Adds an init sequencer that clears both memories before raising `ready`, a synchronised keyboard register, and a sticky illegal-write flag.

## Interface
- `DATA_W`, 16, word width of RAM, screen and `out`
- `ADDR_W`, 15, CPU address width
- `RAM_DEPTH`, 16384, RAM words, mapped at address 0
- `SCREEN_BASE`, 16384, first screen address; must be ≥ `RAM_DEPTH`
- `SCREEN_DEPTH`, 8192, screen words; `SA_W = clog2(SCREEN_DEPTH)`
- `KBD_ADDR`, 24576, keyboard register address; must be ≥ `SCREEN_BASE+SCREEN_DEPTH`
- `INIT_WAIT`, 25000000, power-up wait cycles (≥1)
- `CLEAR_ON_INIT`, 1, 1 = zero both memories before ready

- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  in  ADDR_W  CPU word address
- `in`  in  DATA_W  CPU write data
- `load`  in  1  CPU write strobe
- `keyboard`  in  8  raw key code, asynchronous to `clk`
- `out`  out  DATA_W  CPU read data
- `screen_read_address`  in  SA_W  scan-out read address
- `screen_q`  out  DATA_W  scan-out read data
- `ready`  out  1  memory initialised, CPU may run
- `bad_access`  out  1  sticky: write to keyboard or unmapped address seen

## Operation
- Regions: RAM `address < RAM_DEPTH`; SCREEN `SCREEN_BASE ≤ address < SCREEN_BASE+SCREEN_DEPTH`, index `address-SCREEN_BASE` truncated to SA_W; KBD `address == KBD_ADDR`; all else UNMAPPED.
- FSM states: WAIT, CLEAR, RUN. Reset enters WAIT with wait counter 0.
- WAIT: count to `INIT_WAIT-1`, then go to CLEAR (`CLEAR_ON_INIT=1`) or RUN.
- CLEAR: index 0..`max(RAM_DEPTH,SCREEN_DEPTH)-1`, one word per cycle; each cycle write 0 to RAM[idx] if idx<RAM_DEPTH and to screen[idx] if idx<SCREEN_DEPTH. After last index go to RUN.
- RUN: `ready=1`; stays until reset.
- CPU writes: effective only in RUN. `load` in RAM/SCREEN region writes `in` on that edge. `load` outside RUN dropped silently (no flag). `load` in RUN to KBD or UNMAPPED: no write, `bad_access` set; it clears only on reset.
- CPU reads: region of `address` registered with the read. RAM/SCREEN: synchronous read; KBD: `{zeros, kbd_sync}`; UNMAPPED: 0. Reads are live in all states (return whatever memory holds).
- Keyboard: 2-flop synchroniser on `keyboard`, no debounce.
- Screen scan-out port: independent synchronous read; never stalls, works in all states, sees CLEAR zeroes.
- Same-address read and write in one cycle (CPU port or scan-out vs CPU write): read returns old data.
- Reset mid-CLEAR or in RUN: `ready` drops immediately, FSM restarts at WAIT; memory contents not reset by `reset_n` itself, only by CLEAR.

## Timing
- Reset values: `out=0`, `screen_q=0`, `ready=0`, `bad_access=0`, synchroniser 0.
- `out` valid one cycle after `address` sampled (1-cycle latency, all regions).
- `screen_q` one cycle after `screen_read_address`.
- Keyboard change visible at `out` ≤3 cycles after the edge sampling it (2 sync + 1 read).
- `ready` rises on edge number `INIT_WAIT + CLEAR_ON_INIT·max(RAM_DEPTH,SCREEN_DEPTH)` after first edge with `reset_n=1`.
- Written word readable by a read issued on the cycle after the write edge.
- `bad_access` asserts on the edge capturing the illegal `load`.

## Test plan
Bench parameters: `ADDR_W=5, RAM_DEPTH=16, SCREEN_BASE=16, SCREEN_DEPTH=8, KBD_ADDR=24, INIT_WAIT=4`.
- Reset release, idle -> `ready` low for 20 edges, high on edge 20; RAM[0..15] and screen[0..7] read 0 (preloaded with 0xFFFF in sim).
- RUN: write 0x1234 @3, 0xBEEF @18 -> reads of 3 and 18 return 0x1234 / 0xBEEF one cycle later; `screen_read_address=2` gives 0xBEEF.
- `load` @5 with 0xAAAA during WAIT -> RAM[5] stays 0 after ready, `bad_access=0`.
- Write @24 and @30 in RUN -> no memory change, `bad_access=1` held until `reset_n` pulse; read @30 returns 0.
- `keyboard=0x41` -> read @24 returns 0x0041 within 3 cycles; write @18 with scan-out reading 2 same cycle -> `screen_q` old value then new.
- Assert `reset_n` at clear index 10 -> `ready=0`, restart; ready again exactly 20 edges after release.
